// File: rtl/beatmap_pkg.sv
// Shared widths, FSM encoding and bank indices for the beatmap ping-pong RAM pair.
package beatmap_pkg;

  localparam int BEAT_DATA_W = 8;
  localparam int BEAT_ADDR_W = 5;
  localparam int BEAT_DEPTH  = 32;

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_FREE = 1'b1
  } wr_state_t;

  localparam logic BANK_RAM1 = 1'b0;
  localparam logic BANK_RAM2 = 1'b1;

  function automatic logic other_bank(input logic bank);
    return ~bank;
  endfunction

endpackage

// File: rtl/beat_pingpong_writer_flags.sv
// Reader-ownership flags and latched lengths for the two banks.
// Len latches one edge after handover, full one edge later; release takes effect on the next edge.
module pingpong_bank_flags
  import beatmap_pkg::*;
#(
  parameter int ADDR_W = BEAT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hand_vld,
  input  logic              hand_bank,
  input  logic [ADDR_W:0]   hand_len,
  input  logic [1:0]        rd_release,
  output logic [1:0]        bank_full,
  output logic [1:0]        full_nxt,
  output logic [ADDR_W:0]   bank1_len,
  output logic [ADDR_W:0]   bank2_len
);

  logic [1:0] pend;

  // A pending set always wins; a release only affects a bank the reader already owns.
  assign full_nxt = pend | (bank_full & ~rd_release);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      bank_full <= '0;
      bank1_len <= '0;
      bank2_len <= '0;
    end else begin
      pend      <= '0;
      bank_full <= full_nxt;
      if (bank_full[BANK_RAM1] && rd_release[BANK_RAM1]) begin
        bank1_len <= '0;
      end
      if (bank_full[BANK_RAM2] && rd_release[BANK_RAM2]) begin
        bank2_len <= '0;
      end
      if (hand_vld) begin
        pend[hand_bank] <= 1'b1;
        if (hand_bank == BANK_RAM1) begin
          bank1_len <= hand_len;
        end else begin
          bank2_len <= hand_len;
        end
      end
    end
  end

endmodule

// File: rtl/beat_pingpong_writer.sv
// Fills ram1/ram2 alternately from a valid/ready beat stream and hands full banks to the reader.
// Write strobe one cycle after accept; in_ready drops while the next bank is still owned by the reader.
module beat_pingpong_writer
  import beatmap_pkg::*;
#(
  parameter int DATA_W = BEAT_DATA_W,
  parameter int ADDR_W = BEAT_ADDR_W,
  parameter int DEPTH  = BEAT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  input  logic [1:0]        rd_release,
  output logic              ram1_write_en,
  output logic [ADDR_W-1:0] ram1_write_address,
  output logic [DATA_W-1:0] ram1_write_data,
  output logic              ram2_write_en,
  output logic [ADDR_W-1:0] ram2_write_address,
  output logic [DATA_W-1:0] ram2_write_data,
  output logic [1:0]        bank_full,
  output logic [ADDR_W:0]   bank1_len,
  output logic [ADDR_W:0]   bank2_len,
  output logic              wr_bank
);

  localparam int LEN_W = ADDR_W + 1;

  wr_state_t         state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              handover;
  logic [ADDR_W:0]   fill_len;
  logic [1:0]        full_nxt;

  assign accept   = in_valid & in_ready;
  assign fill_len = {1'b0, wr_ptr} + LEN_W'(accept);
  // Flush of an empty bank is a no-op; a same-cycle accept makes the bank non-empty.
  assign handover = (accept && (wr_ptr == ADDR_W'(DEPTH - 1)))
                  || (flush && ((wr_ptr != '0) || accept));

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= FILL;
      wr_bank            <= BANK_RAM1;
      wr_ptr             <= '0;
      in_ready           <= 1'b0;
      ram1_write_en      <= 1'b0;
      ram1_write_address <= '0;
      ram1_write_data    <= '0;
      ram2_write_en      <= 1'b0;
      ram2_write_address <= '0;
      ram2_write_data    <= '0;
    end else begin
      ram1_write_en <= accept && (wr_bank == BANK_RAM1);
      ram2_write_en <= accept && (wr_bank == BANK_RAM2);
      if (accept && (wr_bank == BANK_RAM1)) begin
        ram1_write_address <= wr_ptr;
        ram1_write_data    <= in_data;
      end
      if (accept && (wr_bank == BANK_RAM2)) begin
        ram2_write_address <= wr_ptr;
        ram2_write_data    <= in_data;
      end

      case (state)
        FILL: begin
          if (handover) begin
            wr_bank <= other_bank(wr_bank);
            wr_ptr  <= '0;
            // The next bank may still be held by the reader, or be about to be handed over.
            if (full_nxt[other_bank(wr_bank)]) begin
              state    <= WAIT_FREE;
              in_ready <= 1'b0;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end else begin
            if (accept) begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            in_ready <= 1'b1;
          end
        end
        WAIT_FREE: begin
          if (!full_nxt[wr_bank]) begin
            state    <= FILL;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state    <= FILL;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  pingpong_bank_flags #(
    .ADDR_W(ADDR_W)
  ) u_flags (
    .clk       (clk),
    .reset     (reset),
    .hand_vld  (handover),
    .hand_bank (wr_bank),
    .hand_len  (fill_len),
    .rd_release(rd_release),
    .bank_full (bank_full),
    .full_nxt  (full_nxt),
    .bank1_len (bank1_len),
    .bank2_len (bank2_len)
  );

endmodule

// File: tb/tb_beat_pingpong_writer.sv
// Scoreboard bench for beat_pingpong_writer: directed test-plan sequences followed by random traffic.
module tb_beat_pingpong_writer;

  localparam int DEPTH = 32;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic [1:0] rd_release;
  logic       ram1_write_en;
  logic [4:0] ram1_write_address;
  logic [7:0] ram1_write_data;
  logic       ram2_write_en;
  logic [4:0] ram2_write_address;
  logic [7:0] ram2_write_data;
  logic [1:0] bank_full;
  logic [5:0] bank1_len;
  logic [5:0] bank2_len;
  logic       wr_bank;

  beat_pingpong_writer dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .flush             (flush),
    .rd_release        (rd_release),
    .ram1_write_en     (ram1_write_en),
    .ram1_write_address(ram1_write_address),
    .ram1_write_data   (ram1_write_data),
    .ram2_write_en     (ram2_write_en),
    .ram2_write_address(ram2_write_address),
    .ram2_write_data   (ram2_write_data),
    .bank_full         (bank_full),
    .bank1_len         (bank1_len),
    .bank2_len         (bank2_len),
    .wr_bank           (wr_bank)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words collected per bank, reader ownership per bank, lengths handed over.
  typedef struct {
    bit         bank;
    int         addr;
    logic [7:0] data;
  } wexp_t;
  typedef struct {
    bit bank;
    int len;
  } hexp_t;

  wexp_t      wq[$];
  hexp_t      hq[$];
  bit         m_bank;
  int         m_cnt;
  logic [1:0] m_full;
  logic [1:0] m_pend;
  int         m_len[2];
  int         m_last_addr[2];
  int         m_last_data[2];
  bit         exp_rdy;
  bit         mon_en;

  task automatic model_step(input bit v, input logic [7:0] d, input bit f,
                            input logic [1:0] rel, input bit rst);
    logic [1:0] owned_next;
    bit acc;
    if (rst) begin
      wq.delete();
      hq.delete();
      m_bank = 0;
      m_cnt = 0;
      m_full = '0;
      m_pend = '0;
      exp_rdy = 0;
      for (int i = 0; i < 2; i++) begin
        m_len[i] = 0;
        m_last_addr[i] = 0;
        m_last_data[i] = 0;
      end
      return;
    end
    acc = v && exp_rdy;
    if (acc) begin
      wq.push_back('{m_bank, m_cnt, d});
      m_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_pend[i]) owned_next[i] = 1'b1;
      else if (m_full[i] && rel[i]) begin
        owned_next[i] = 1'b0;
        m_len[i] = 0;
      end else owned_next[i] = m_full[i];
    end
    m_pend = '0;
    if ((acc && m_cnt == DEPTH) || (f && m_cnt > 0)) begin
      hq.push_back('{m_bank, m_cnt});
      m_len[m_bank] = m_cnt;
      m_pend[m_bank] = 1'b1;
      m_bank = !m_bank;
      m_cnt = 0;
    end
    m_full = owned_next;
    exp_rdy = !m_full[m_bank];
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit f,
                      input logic [1:0] rel, input bit rst);
    in_valid = v;
    in_data = d;
    flush = f;
    rd_release = rel;
    reset = rst;
    @(posedge clk);
    model_step(v, d, f, rel, rst);
    #1;
    in_valid = 0;
    flush = 0;
    rd_release = '0;
    reset = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 2'b00, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_bank_full"}, bank_full, 0);
    chk({tag, "_lens"}, {bank1_len, bank2_len}, 0);
    chk({tag, "_wr_bank"}, wr_bank, 0);
    chk({tag, "_ram1"}, {ram1_write_en, ram1_write_address, ram1_write_data}, 0);
    chk({tag, "_ram2"}, {ram2_write_en, ram2_write_address, ram2_write_data}, 0);
  endtask

  // Monitor: consumes expected strobes and handovers, and compares the visible flag state.
  logic [1:0] prev_full;
  always @(negedge clk) begin : mon
    wexp_t e;
    hexp_t h;
    if (mon_en) begin
      if (ram1_write_en && ram2_write_en) chk("dual_strobe", 2'b11, 2'b00);
      if (ram1_write_en || ram2_write_en || wq.size() > 0) begin
        if (wq.size() == 0) begin
          chk("unexpected_strobe", {ram2_write_en, ram1_write_en}, 2'b00);
        end else begin
          e = wq.pop_front();
          chk("strobe_bank", {ram2_write_en, ram1_write_en}, e.bank ? 2'b10 : 2'b01);
          m_last_addr[e.bank] = e.addr;
          m_last_data[e.bank] = e.data;
        end
      end
      chk("ram1_addr", ram1_write_address, m_last_addr[0]);
      chk("ram1_data", ram1_write_data, m_last_data[0]);
      chk("ram2_addr", ram2_write_address, m_last_addr[1]);
      chk("ram2_data", ram2_write_data, m_last_data[1]);
      chk("in_ready", in_ready, exp_rdy);
      chk("wr_bank", wr_bank, m_bank);
      chk("bank_full", bank_full, m_full);
      chk("bank1_len", bank1_len, m_len[0]);
      chk("bank2_len", bank2_len, m_len[1]);
      for (int i = 0; i < 2; i++) begin
        if (bank_full[i] && !prev_full[i]) begin
          if (hq.size() == 0) begin
            chk("unexpected_handover", i, 32'hffff_ffff);
          end else begin
            h = hq.pop_front();
            chk("handover_bank", i, h.bank);
            chk("handover_len", i == 0 ? bank1_len : bank2_len, h.len);
          end
        end
      end
    end
    prev_full = bank_full;
  end

  initial begin
    clk = 0;
    in_valid = 0;
    in_data = 0;
    flush = 0;
    rd_release = 0;
    reset = 1;
    checks = 0;
    failures = 0;
    mon_en = 0;
    prev_full = '0;
    step(0, 8'h00, 0, 2'b00, 1);
    step(0, 8'h00, 0, 2'b00, 1);
    mon_en = 1;
    check_all_zero("reset");
    idle(1);
    chk("t1_ready_after_reset", in_ready, 1);

    // 1: fill ram1 with 0x00..0x1F back to back
    for (int i = 0; i < 32; i++) step(1, 8'(i), 0, 2'b00, 0);
    chk("t1_last_strobe", {ram1_write_en, ram1_write_address, ram1_write_data},
        {1'b1, 5'd31, 8'h1f});
    chk("t1_full_not_yet", bank_full, 2'b00);
    idle(1);
    chk("t1_full", bank_full, 2'b01);
    chk("t1_len", bank1_len, 32);
    chk("t1_wr_bank", wr_bank, 1);
    chk("t1_ready", in_ready, 1);

    // 2: fill ram2, hold valid under backpressure, release ram1
    for (int i = 0; i < 32; i++) step(1, 8'(8'h20 + i), 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) step(1, 8'hee, 0, 2'b00, 0);
    chk("t2_full", bank_full, 2'b11);
    chk("t2_ready_low", in_ready, 0);
    step(1, 8'hee, 0, 2'b01, 0);
    chk("t2_ready_back", in_ready, 1);
    step(1, 8'ha5, 0, 2'b00, 0);
    chk("t2_first_after_release", {ram1_write_en, ram1_write_address, ram1_write_data},
        {1'b1, 5'd0, 8'ha5});

    // 3: partial fill then flush; empty flush ignored
    step(0, 8'h00, 0, 2'b00, 1);
    check_all_zero("t3_reset");
    idle(1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 2'b00, 0);
    step(0, 8'h00, 1, 2'b00, 0);
    idle(1);
    chk("t3_full", bank_full, 2'b01);
    chk("t3_len", bank1_len, 5);
    step(0, 8'h00, 1, 2'b00, 0);
    idle(2);
    chk("t3_empty_flush_full", bank_full, 2'b01);
    chk("t3_empty_flush_bank", wr_bank, 1);
    step(1, 8'h3c, 0, 2'b00, 0);
    chk("t3_ram2_first", {ram2_write_en, ram2_write_address, ram2_write_data},
        {1'b1, 5'd0, 8'h3c});

    // 4: flush together with the 8th accept
    step(0, 8'h00, 0, 2'b00, 1);
    idle(1);
    for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0, 2'b00, 0);
    step(1, 8'h77, 1, 2'b00, 0);
    chk("t4_last_strobe", {ram1_write_en, ram1_write_address, ram1_write_data},
        {1'b1, 5'd7, 8'h77});
    chk("t4_len", bank1_len, 8);
    idle(1);
    chk("t4_full", bank_full, 2'b01);

    // 5: release of an unowned bank, then reset mid-fill
    step(0, 8'h00, 0, 2'b10, 0);
    idle(1);
    chk("t5_bad_release", bank_full, 2'b01);
    for (int i = 0; i < 12; i++) step(1, 8'(8'h90 + i), 0, 2'b00, 0);
    step(1, 8'hff, 0, 2'b00, 1);
    check_all_zero("t5_reset");
    idle(1);
    step(1, 8'h42, 0, 2'b00, 0);
    chk("t5_after_reset", {ram1_write_en, ram1_write_address, ram1_write_data},
        {1'b1, 5'd0, 8'h42});

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] rel;
      rel[0] = ($urandom_range(0, 99) < 8);
      rel[1] = ($urandom_range(0, 99) < 8);
      step($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 3, rel,
           $urandom_range(0, 999) < 2);
    end
    idle(3);
    chk("end_strobes_drained", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
